// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: load-use bubbles, branch flushes
// and whole-pipeline freeze during multi-cycle data-memory accesses. Optional timeout abort: PIPE_MEM_TIMEOUT_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IDEX_MemRead_i,
    input  logic [REG_AW-1:0] IDEX_Rt_i,
    input  logic [REG_AW-1:0] IFID_Rs_i,
    input  logic [REG_AW-1:0] IFID_Rt_i,
    input  logic              Branch_taken_i,
    input  logic              EXMEM_MemRead_i,
    input  logic              EXMEM_MemWrite_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              PC_Write_o,
    output logic              IFID_Write_o,
    output logic              IFID_Flush_o,
    output logic              IDEX_Bubble_o,
    output logic              Freeze_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              mem_err_o
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_next;
    logic             mem_acc;
    logic             load_use;
    logic             freeze;
    logic             stall;
    logic             timeout;
    logic [CNT_W-1:0] stall_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign mem_acc  = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    // A load into $0 never produces a value, so it can never be a hazard.
    assign load_use = IDEX_MemRead_i & (IDEX_Rt_i != '0) &
                      ((IDEX_Rt_i == IFID_Rs_i) | (IDEX_Rt_i == IFID_Rt_i));

    always_comb begin
        state_next    = state;
        freeze        = 1'b0;
        mem_req_o     = 1'b0;
        PC_Write_o    = 1'b0;
        IFID_Write_o  = 1'b0;
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;

        case (state)
            RUN: begin
                if (mem_acc) begin
                    freeze     = 1'b1;
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                freeze    = 1'b1;
                mem_req_o = 1'b1;
                if (mem_ack_i || timeout) begin
                    state_next = MEM_DONE;
                end
            end
            // The pipeline advances once here so the served access is not seen again.
            MEM_DONE: state_next = RUN;
            default:  state_next = RUN;
        endcase

        if (!rst_i) begin
            freeze    = 1'b0;
            mem_req_o = 1'b0;
        end else if (!freeze) begin
            if (load_use) begin
                IDEX_Bubble_o = 1'b1;
            end else begin
                PC_Write_o   = 1'b1;
                IFID_Write_o = 1'b1;
                IFID_Flush_o = Branch_taken_i;
            end
        end
    end

    assign Freeze_o    = freeze;
    assign stall       = freeze | load_use;
    assign stall_cnt_o = stall_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

`ifdef PIPE_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] to_cnt;
    logic            err;

    // An ack arriving on the final allowed cycle wins over the timeout.
    assign timeout = (state == MEM_WAIT) && !mem_ack_i && (to_cnt == TO_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == MEM_WAIT) begin
                to_cnt <= to_cnt + TO_ONE;
            end else begin
                to_cnt <= '0;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    assign mem_err_o = err;
`else
    assign timeout   = 1'b0;
    assign mem_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver pushes model expectations per cycle,
// a monitor pops and compares at the falling edge. Honours PIPE_MEM_TIMEOUT_EN when defined.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW      = 5;
    localparam int CNT_W       = 6;
    localparam int TIMEOUT_CYC = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              IDEX_MemRead_i;
    logic [REG_AW-1:0] IDEX_Rt_i;
    logic [REG_AW-1:0] IFID_Rs_i;
    logic [REG_AW-1:0] IFID_Rt_i;
    logic              Branch_taken_i;
    logic              EXMEM_MemRead_i;
    logic              EXMEM_MemWrite_i;
    logic              mem_ack_i;
    logic              mem_req_o;
    logic              PC_Write_o;
    logic              IFID_Write_o;
    logic              IFID_Flush_o;
    logic              IDEX_Bubble_o;
    logic              Freeze_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic              mem_err_o;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW      (REG_AW),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .IDEX_MemRead_i   (IDEX_MemRead_i),
        .IDEX_Rt_i        (IDEX_Rt_i),
        .IFID_Rs_i        (IFID_Rs_i),
        .IFID_Rt_i        (IFID_Rt_i),
        .Branch_taken_i   (Branch_taken_i),
        .EXMEM_MemRead_i  (EXMEM_MemRead_i),
        .EXMEM_MemWrite_i (EXMEM_MemWrite_i),
        .mem_ack_i        (mem_ack_i),
        .mem_req_o        (mem_req_o),
        .PC_Write_o       (PC_Write_o),
        .IFID_Write_o     (IFID_Write_o),
        .IFID_Flush_o     (IFID_Flush_o),
        .IDEX_Bubble_o    (IDEX_Bubble_o),
        .Freeze_o         (Freeze_o),
        .stall_cnt_o      (stall_cnt_o),
        .mem_err_o        (mem_err_o)
    );

    typedef struct {
        logic req;
        logic pcw;
        logic ifw;
        logic flush;
        logic bubble;
        logic freeze;
        logic err;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: an outstanding request, a one-cycle "just served" slot, cycles waited.
    bit m_waiting = 0;
    bit m_served  = 0;
    bit m_err     = 0;
    int m_waited  = 0;
    int m_cnt     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic mr, input logic [REG_AW-1:0] idrt,
                         input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                         input logic br, input logic emr, input logic emw, input logic ack);
        exp_t e;
        bit   acc;
        bit   lu;
        bit   frz;
        rst_i            = rst;
        IDEX_MemRead_i   = mr;
        IDEX_Rt_i        = idrt;
        IFID_Rs_i        = rs;
        IFID_Rt_i        = rt;
        Branch_taken_i   = br;
        EXMEM_MemRead_i  = emr;
        EXMEM_MemWrite_i = emw;
        mem_ack_i        = ack;
        if (!rst) begin
            m_waiting = 0;
            m_served  = 0;
            m_err     = 0;
            m_waited  = 0;
            m_cnt     = 0;
        end
        acc = emr || emw;
        lu  = mr && (idrt != 0) && (idrt == rs || idrt == rt);
        frz = rst && (m_waiting || (!m_served && acc));
        e.freeze = frz;
        e.req    = rst && m_waiting;
        e.pcw    = rst && !frz && !lu;
        e.ifw    = e.pcw;
        e.flush  = e.pcw && br;
        e.bubble = rst && !frz && lu;
        e.cnt    = m_cnt;
        e.err    = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            if (frz || lu) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (m_served) begin
                m_served = 0;
            end else if (m_waiting) begin
                m_waited++;
                if (ack) begin
                    m_waiting = 0;
                    m_served  = 1;
                end
`ifdef PIPE_MEM_TIMEOUT_EN
                else if (m_waited == TIMEOUT_CYC) begin
                    m_waiting = 0;
                    m_served  = 1;
                    m_err     = 1;
                end
`endif
            end else if (acc) begin
                m_waiting = 1;
                m_waited  = 0;
            end
        end
    endtask

    task automatic idle(input logic rst);
        drive(rst, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("mem_req", mem_req_o, e.req);
                check("pc_write", PC_Write_o, e.pcw);
                check("ifid_write", IFID_Write_o, e.ifw);
                check("ifid_flush", IFID_Flush_o, e.flush);
                check("idex_bubble", IDEX_Bubble_o, e.bubble);
                check("freeze", Freeze_o, e.freeze);
                check("stall_cnt", stall_cnt_o, e.cnt);
                check("mem_err", mem_err_o, e.err);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0; IDEX_MemRead_i = 0; IDEX_Rt_i = 0; IFID_Rs_i = 0; IFID_Rt_i = 0;
        Branch_taken_i = 0; EXMEM_MemRead_i = 0; EXMEM_MemWrite_i = 0; mem_ack_i = 0;
        repeat (2) @(posedge clk);
        #1;
        // reset held with activity on every input: outputs must stay 0
        drive(0, 1, 8, 8, 0, 1, 1, 0, 1);
        idle(0);
        idle(1);

        // load-use on r8, then the $0 case
        drive(1, 1, 8, 8, 3, 0, 0, 0, 0);
        drive(1, 1, 8, 2, 8, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 8, 8, 8, 0, 0, 0, 0);

        // branch flush, then branch masked by load-use
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 8, 1, 8, 1, 0, 0, 0);
        idle(1);

        // load with ack on the third wait cycle; load still visible in the done cycle
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // back-to-back stores
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // reset while waiting for memory
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        idle(1);

`ifdef PIPE_MEM_TIMEOUT_EN
        // ack on the last allowed cycle is a normal completion
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT_CYC; i++) drive(1, 0, 0, 0, 0, 0, 1, 0, (i == TIMEOUT_CYC - 1));
        idle(1);
        idle(1);
        // no ack: abort and sticky error
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT_CYC; i++) drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) idle(1);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        idle(1);
`endif

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 1) == 0),
                  REG_AW'($urandom_range(0, 3)),
                  REG_AW'($urandom_range(0, 3)),
                  REG_AW'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0));
        end
        idle(1);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
